// File: rtl/guitar_pkg.sv
// Shared constants and types for the chart composer and playback stages.
package guitar_pkg;

   localparam logic [2:0] MODE_COMPOSE = 3'd3;
   localparam logic [2:0] MODE_PLAY    = 3'd4;
   localparam int         NUM_STEPS    = 32;
   localparam int         STEP_W       = $clog2(NUM_STEPS + 1);

   typedef enum logic [1:0] {
      CC_IDLE,
      CC_COMPOSE,
      CC_FULL
   } cc_state_t;

endpackage

// File: rtl/chart_composer_if.sv
// Button inputs, mode and chart outputs of the chart composer.
interface chart_composer_if
   import guitar_pkg::*;
#(
   parameter int N_STEPS = NUM_STEPS,
   parameter int S_W     = STEP_W
);

   logic [2:0]         mode;
   logic               lane1_btn;
   logic               lane2_btn;
   logic               commit_btn;
   logic               clear_btn;
   logic [N_STEPS-1:0] notes1;
   logic [N_STEPS-1:0] notes2;
   logic [1:0]         pending;
   logic [S_W-1:0]     step;
   logic               done;

   modport master (
      output mode, lane1_btn, lane2_btn, commit_btn, clear_btn,
      input  notes1, notes2, pending, step, done
   );

   modport slave (
      input  mode, lane1_btn, lane2_btn, commit_btn, clear_btn,
      output notes1, notes2, pending, step, done
   );

endinterface

// File: rtl/btn_edge_sync.sv
// Raw button synchroniser followed by a rising-edge detector.
module btn_edge_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic n_rst,
   input  logic btn_i,
   output logic pulse_o
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   last_q;

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         sync_q <= '0;
         last_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], btn_i};
         last_q <= sync_q[SYNC_STAGES-1];
      end
   end

   // last_q resets low, so a button held through reset gives one event
   assign pulse_o = sync_q[SYNC_STAGES-1] & ~last_q;

endmodule

// File: rtl/chart_composer.sv
// Compose-mode chart writer: builds two lane patterns from button presses.
module chart_composer
   import guitar_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             n_rst,
   chart_composer_if.slave  bus
);

   localparam int IDX_W = $clog2(NUM_STEPS);

   cc_state_t            state_q, state_d;
   logic [NUM_STEPS-1:0] notes1_q, notes1_d;
   logic [NUM_STEPS-1:0] notes2_q, notes2_d;
   logic [1:0]           pending_q, pending_d;
   logic [STEP_W-1:0]    step_q, step_d;

   logic                 lane1_ev, lane2_ev, commit_ev, clear_ev;
   logic                 compose;
   logic [1:0]           pend_nx;
   logic [IDX_W-1:0]     idx;

   btn_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_l1 (
      .clk(clk), .n_rst(n_rst), .btn_i(bus.lane1_btn), .pulse_o(lane1_ev)
   );
   btn_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_l2 (
      .clk(clk), .n_rst(n_rst), .btn_i(bus.lane2_btn), .pulse_o(lane2_ev)
   );
   btn_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_cm (
      .clk(clk), .n_rst(n_rst), .btn_i(bus.commit_btn), .pulse_o(commit_ev)
   );
   btn_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_cl (
      .clk(clk), .n_rst(n_rst), .btn_i(bus.clear_btn), .pulse_o(clear_ev)
   );

   assign compose = (bus.mode == MODE_COMPOSE);
   assign pend_nx = pending_q ^ {lane1_ev, lane2_ev};
   // step 0 lands in the MSB so it scrolls out first
   assign idx     = IDX_W'(NUM_STEPS - 1) - step_q[IDX_W-1:0];

   always_comb begin
      state_d   = state_q;
      notes1_d  = notes1_q;
      notes2_d  = notes2_q;
      pending_d = pending_q;
      step_d    = step_q;
      unique case (state_q)
         CC_IDLE: begin
            if (compose) begin
               state_d   = CC_COMPOSE;
               notes1_d  = '0;
               notes2_d  = '0;
               pending_d = '0;
               step_d    = '0;
            end
         end
         CC_COMPOSE: begin
            if (!compose) begin
               state_d   = CC_IDLE;
               pending_d = '0;
            end else if (clear_ev) begin
               notes1_d  = '0;
               notes2_d  = '0;
               pending_d = '0;
               step_d    = '0;
            end else begin
               pending_d = pend_nx;
               if (commit_ev) begin
                  notes1_d[idx] = pend_nx[1];
                  notes2_d[idx] = pend_nx[0];
                  pending_d     = '0;
                  step_d        = step_q + 1'b1;
                  if (step_q == STEP_W'(NUM_STEPS - 1))
                     state_d = CC_FULL;
               end
            end
         end
         CC_FULL: begin
            if (!compose) begin
               state_d   = CC_IDLE;
               pending_d = '0;
            end else if (clear_ev) begin
               state_d   = CC_COMPOSE;
               notes1_d  = '0;
               notes2_d  = '0;
               pending_d = '0;
               step_d    = '0;
            end
         end
         default: begin
            state_d   = CC_IDLE;
            pending_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q   <= CC_IDLE;
         notes1_q  <= '0;
         notes2_q  <= '0;
         pending_q <= '0;
         step_q    <= '0;
      end else begin
         state_q   <= state_d;
         notes1_q  <= notes1_d;
         notes2_q  <= notes2_d;
         pending_q <= pending_d;
         step_q    <= step_d;
      end
   end

   assign bus.notes1  = notes1_q;
   assign bus.notes2  = notes2_q;
   assign bus.pending = pending_q;
   assign bus.step    = step_q;
   assign bus.done    = (state_q == CC_FULL);

endmodule

// File: tb/tb_chart_composer.sv
// Directed bench for chart_composer with hand-computed chart values.
module tb_chart_composer;
   import guitar_pkg::*;

   logic clk;
   logic n_rst;
   int   n_run;
   int   n_fail;

   chart_composer_if bus ();

   chart_composer #(.SYNC_STAGES(2)) u_dut (
      .clk(clk),
      .n_rst(n_rst),
      .bus(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      n_run++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // mask bits: {clear, commit, lane2, lane1}
   task automatic drive(input logic [3:0] m);
      bus.lane1_btn  = m[0];
      bus.lane2_btn  = m[1];
      bus.commit_btn = m[2];
      bus.clear_btn  = m[3];
   endtask

   // one-cycle raw pulse; returns once the event has been registered
   task automatic press(input logic [3:0] m);
      @(negedge clk);
      drive(m);
      @(negedge clk);
      drive(4'b0000);
      @(negedge clk);
      @(negedge clk);
   endtask

   initial begin
      n_run  = 0;
      n_fail = 0;
      n_rst  = 1'b0;
      bus.mode = 3'd3;
      drive(4'b0001);

      // 1: lane1 held through reset release
      repeat (3) @(negedge clk);
      n_rst = 1'b1;
      #1;
      chk("rst_notes1", 64'(bus.notes1), 64'h0);
      chk("rst_notes2", 64'(bus.notes2), 64'h0);
      chk("rst_pend", 64'(bus.pending), 64'h0);
      chk("rst_step", 64'(bus.step), 64'h0);
      chk("rst_done", 64'(bus.done), 64'h0);
      @(negedge clk);
      chk("hold_e1", 64'(bus.pending), 64'h0);
      @(negedge clk);
      chk("hold_e2", 64'(bus.pending), 64'h0);
      @(negedge clk);
      chk("hold_e3", 64'(bus.pending), 64'h2);
      drive(4'b0000);
      repeat (4) @(negedge clk);
      chk("hold_once", 64'(bus.pending), 64'h2);

      // 2: basic pattern
      press(4'b1000);
      chk("clr_pend", 64'(bus.pending), 64'h0);
      press(4'b0001);
      press(4'b0100);
      press(4'b0010);
      chk("t2_pend", 64'(bus.pending), 64'h1);
      press(4'b0100);
      press(4'b0100);
      chk("t2_n1", 64'(bus.notes1), 64'h8000_0000);
      chk("t2_n2", 64'(bus.notes2), 64'h4000_0000);
      chk("t2_step", 64'(bus.step), 64'd3);
      chk("t2_pend0", 64'(bus.pending), 64'h0);

      // 3: lane1 and commit together
      press(4'b1000);
      press(4'b0101);
      chk("t3_n1", 64'(bus.notes1), 64'h8000_0000);
      chk("t3_pend", 64'(bus.pending), 64'h0);
      chk("t3_step", 64'(bus.step), 64'd1);

      // 4: fill the whole chart
      press(4'b1000);
      for (int k = 0; k < 32; k++) begin
         if (k % 2 == 0) press(4'b0001);
         press(4'b0100);
      end
      chk("t4_n1", 64'(bus.notes1), 64'hAAAA_AAAA);
      chk("t4_n2", 64'(bus.notes2), 64'h0);
      chk("t4_step", 64'(bus.step), 64'd32);
      chk("t4_done", 64'(bus.done), 64'h1);
      press(4'b0001);
      press(4'b0100);
      chk("t4_ovf_n1", 64'(bus.notes1), 64'hAAAA_AAAA);
      chk("t4_ovf_step", 64'(bus.step), 64'd32);
      chk("t4_ovf_pend", 64'(bus.pending), 64'h0);

      // 5: clear beats commit mid-chart
      press(4'b1000);
      chk("t5_done0", 64'(bus.done), 64'h0);
      for (int k = 0; k < 10; k++) press(4'b0110);
      chk("t5_n2", 64'(bus.notes2), 64'hFFC0_0000);
      chk("t5_step10", 64'(bus.step), 64'd10);
      press(4'b1100);
      chk("t5_n1", 64'(bus.notes1), 64'h0);
      chk("t5_n2c", 64'(bus.notes2), 64'h0);
      chk("t5_step", 64'(bus.step), 64'd0);
      chk("t5_done", 64'(bus.done), 64'h0);

      // 6: mode exit, re-entry and async reset
      press(4'b0101);
      press(4'b0010);
      chk("t6_pend", 64'(bus.pending), 64'h1);
      bus.mode = MODE_PLAY;
      @(negedge clk);
      chk("t6_n1", 64'(bus.notes1), 64'h8000_0000);
      chk("t6_drop", 64'(bus.pending), 64'h0);
      chk("t6_step", 64'(bus.step), 64'd1);
      press(4'b0101);
      chk("t6_idle_n1", 64'(bus.notes1), 64'h8000_0000);
      chk("t6_idle_pend", 64'(bus.pending), 64'h0);
      bus.mode = MODE_COMPOSE;
      @(negedge clk);
      chk("t6_re_n1", 64'(bus.notes1), 64'h0);
      chk("t6_re_step", 64'(bus.step), 64'd0);
      press(4'b0101);
      press(4'b0001);
      chk("t6_pre_n1", 64'(bus.notes1), 64'h8000_0000);
      #2;
      n_rst = 1'b0;
      #1;
      chk("t6_ar_n1", 64'(bus.notes1), 64'h0);
      chk("t6_ar_pend", 64'(bus.pending), 64'h0);
      chk("t6_ar_step", 64'(bus.step), 64'd0);
      @(negedge clk);
      n_rst = 1'b1;
      @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
